uart_rx: RTL and testbench
==========================

# uart_rx

8-bit UART receiver, 8N1 (one start bit, eight data bits LSB first, no parity, one stop bit), the receive-side counterpart of the team's UART transmitter. It recovers bytes from the serial line using mid-bit sampling driven by a per-bit clock counter. It presents each received byte with a one-cycle `valid` strobe to the downstream logic that feeds the neural-network input buffers.

## Interface
- `CLK_PER_BIT`, 32: clock cycles per bit, equal to clk_frequency / baud_rate; legal range 4..255.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line, asynchronous to `clk`; idles high.
- `data_out` output 8: last correctly framed byte; holds its value until the next good byte.
- `valid` output 1: one-cycle pulse when `data_out` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a two-flop synchronizer (`sync1` then `rx_s`). Both flops reset to 1. Only `rx_s` feeds the FSM.
- Let N = `CLK_PER_BIT` and H = (N-1)/2, using integer division. The bit counter `cnt` is 8 bits and the bit index `idx` is 3 bits.
- IDLE: `cnt`=0, `idx`=0. When `rx_s`=0, go to START.
- START: while `cnt`<H, increment `cnt`. At `cnt`==H, sample the line:
  - 0: go to DATA, `cnt`=0.
  - 1: this is a false start; go to IDLE and leave all outputs unchanged.
- DATA: while `cnt`<N-1, increment `cnt`. At `cnt`==N-1, sample the line into `shift[idx]` and clear `cnt`.
  - If `idx`==7, go to STOP and set `idx`=0.
  - Otherwise increment `idx`.
- STOP: while `cnt`<N-1, increment `cnt`. At `cnt`==N-1, sample the line:
  - 1: `data_out`<=`shift`, `valid`<=1, go to IDLE.
  - 0: `frame_err`<=1, `data_out` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line (break) from re-triggering frames.
- `valid` and `frame_err` are cleared every cycle unless set as above. They are never high together.
- Illegal state encoding: go to IDLE and clear `cnt` and `idx`.
- `rst` asserted at any time, including mid-frame, takes effect immediately:
  - State goes to IDLE; `cnt`, `idx`, `shift`, `data_out` become 0.
  - `valid`, `frame_err`, `busy` become 0.
  - Any partial byte is discarded.

## Timing
- Reset values: `data_out`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
- Let e0 be the first `clk` edge at which `rx` is captured low.
  - `rx_s` is low after edge e0+1.
  - START is entered at edge e0+2.
  - Data bit k is sampled at edge e0+H+3+(k+1)·N, for k=0..7.
  - Stop is sampled at edge e0+H+3+9·N. `valid` or `frame_err` is high for the one cycle following that edge.
- For N=32 (H=15), the strobe edge is e0+306.
- After a good frame, the FSM is in IDLE about half a bit before the nominal end of the stop bit. This allows back-to-back frames with no idle gap.
- A low pulse shorter than about H+1 cycles at `rx_s` is rejected as a false start. No strobe is produced.
- `busy` rises one cycle after START is entered and falls in the cycle after IDLE is re-entered.

## Configuration
- `UART_RX_MAJORITY_EN` defined: a 3-bit history of `rx_s` is kept. Every sample point (start check, data bits, stop) uses the majority of `rx_s` at the sample edge and the two preceding edges. This adds no latency.
- Not defined: every sample point uses the single `rx_s` value at the sample edge.

## Test plan
- N=32: send 0xA5 with stop=1. Expect `valid` high for exactly one cycle at edge e0+306, `data_out`=0xA5, `frame_err` never high.
- Back-to-back 0x00 then 0xFF with zero idle between frames. Expect two `valid` pulses 320 cycles apart, and `data_out` = 0x00 then 0xFF.
- `rx` low for 5 cycles, then high. Expect `busy` pulses high, then low; no `valid`, no `frame_err`.
- Send 0x3C after a good 0x11, with the stop bit driven low and the line held low for 100 more cycles. Expect a single `frame_err` pulse; `data_out` stays 0x11; no new frame starts until `rx` returns high.
- Assert `rst` during bit 4 of a 0x5A frame, release it, then send 0x81. Expect all outputs 0 during reset, no strobe for the aborted frame, then `valid` with `data_out`=0x81.
- With `UART_RX_MAJORITY_EN` defined: send 0x00 with a one-cycle high glitch on `rx_s` at the bit-3 sample edge. Expect `data_out`=0x00. Without the macro, the same stimulus gives `data_out`=0x08.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-cycle valid/frame_err strobe.
// Optional UART_RX_MAJORITY_EN: each sample point takes a 3-sample majority of the synchronized line.
module uart_rx #(
    parameter int CLK_PER_BIT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [7:0] HALF = 8'((CLK_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST = 8'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t     state, state_n;
    logic       sync1, rx_s;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_n;
    logic       valid_n, ferr_n;
    logic       samp;

`ifdef UART_RX_MAJORITY_EN
    // rx_s as seen at the previous two edges; together with rx_s this gives a zero-latency vote.
    logic [1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rx_s};
    end

    assign samp = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign samp = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= 8'd0;
            idx       <= 3'd0;
            shift     <= 8'd0;
            data_out  <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= rx;
            rx_s      <= sync1;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data_out  <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
            busy      <= (state != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_out;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                idx_n = 3'd0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt < HALF) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n   = 8'd0;
                    state_n = samp ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt < LAST) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n        = 8'd0;
                    shift_n[idx] = samp;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        idx_n   = 3'd0;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt < LAST) begin
                    cnt_n = cnt + 8'd1;
                end else begin
                    cnt_n = 8'd0;
                    if (samp) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            // A held-low line (break) must return high before a new start is accepted.
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
                idx_n   = 3'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx: directed frames, expected strobes queued, monitor compares.
module tb_uart_rx;
    localparam int N = 32;
    localparam int H = (N - 1) / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid, frame_err, busy;

    uart_rx #(.CLK_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         edge_n;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every strobe cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            exp_t e;
            chk("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got valid=%0b frame_err=%0b data=%0h expected none (cycle %0d)",
                         valid, frame_err, data_out, cyc);
            end else begin
                e = sbq.pop_front();
                chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.ferr});
                chk("strobe_data", {24'd0, data_out}, {24'd0, e.data});
                chk("strobe_edge", cyc, e.edge_n);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx = 1'b1;
        end
    endtask

    // Drives ncyc cycles of an 8N1 frame; queues its strobe only if the whole frame is sent.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int glitch, input int ncyc,
                              input bit exp_ferr, input logic [7:0] exp_data);
        int   e0;
        int   b;
        logic v;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                e0 = cyc + 1;
                if (ncyc == 10 * N) sbq.push_back('{exp_ferr, exp_data, e0 + H + 3 + 9 * N});
            end
            b = c / N;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = d[b - 1];
            else             v = stop;
            if (c == glitch) v = 1'b1;
            rx = v;
        end
    endtask

    initial begin
        bit         seen;
        logic [7:0] glitch_exp;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {24'd0, data_out}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1, -1, 10 * N, 1'b0, 8'hA5);
        idle(10);

        send_frame(8'h00, 1'b1, -1, 10 * N, 1'b0, 8'h00);
        send_frame(8'hFF, 1'b1, -1, 10 * N, 1'b0, 8'hFF);
        idle(10);

        seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            rx = (c < 5) ? 1'b0 : 1'b1;
            if (busy) seen = 1'b1;
        end
        chk("false_start_busy_hi", {31'd0, seen}, 32'd1);
        chk("false_start_busy_lo", {31'd0, busy}, 32'd0);

        send_frame(8'h11, 1'b1, -1, 10 * N, 1'b0, 8'h11);
        send_frame(8'h3C, 1'b0, -1, 10 * N, 1'b1, 8'h11);
        repeat (100) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_data_hold", {24'd0, data_out}, 32'h11);
        idle(8);
        chk("break_release_busy", {31'd0, busy}, 32'd0);

        send_frame(8'h5A, 1'b1, -1, 5 * N + 16, 1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_data", {24'd0, data_out}, 32'h00);
        chk("midreset_valid", {31'd0, valid}, 32'd0);
        chk("midreset_ferr", {31'd0, frame_err}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rx  = 1'b1;
        rst = 1'b0;
        idle(5);
        send_frame(8'h81, 1'b1, -1, 10 * N, 1'b0, 8'h81);
        idle(10);

`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        send_frame(8'h00, 1'b1, H + 1 + 4 * N, 10 * N, 1'b0, glitch_exp);
        idle(10);

        for (int i = 0; i < 2000 && sbq.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
